// File: rtl/cmip_pkt_arb_rr.sv
// Packet-granular round-robin arbiter: merges PORT_NUM AXI-Stream sources onto one
// TX stream, holding each grant from the first beat through the tlast beat.
module cmip_pkt_arb_rr #(
    parameter int DATA_WD  = 32,
    parameter int PORT_NUM = 4,
    parameter int GNT_WD   = $clog2(PORT_NUM),
    parameter int CFG_WD   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_rst,
    input  logic [PORT_NUM-1:0]           cfg_en,
    input  logic [PORT_NUM*DATA_WD-1:0]   s_axis_tdata,
    input  logic [PORT_NUM*DATA_WD/8-1:0] s_axis_tkeep,
    input  logic [PORT_NUM-1:0]           s_axis_tvalid,
    output logic [PORT_NUM-1:0]           s_axis_tready,
    input  logic [PORT_NUM-1:0]           s_axis_tlast,
    input  logic [PORT_NUM-1:0]           s_axis_tuser,
    output logic [DATA_WD-1:0]            m_axis_tdata,
    output logic [DATA_WD/8-1:0]          m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          sts_busy,
    output logic [GNT_WD-1:0]             sts_grant,
    output logic [CFG_WD-1:0]             sts_pkt_cnt
);

    localparam int KEEP_WD = DATA_WD / 8;

    typedef enum logic {ARB, XFER} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [GNT_WD-1:0]   gnt;
    logic [GNT_WD-1:0]   last_gnt;
    logic [GNT_WD-1:0]   arb_idx;
    logic [PORT_NUM-1:0] req;
    logic                arb_hit;
    logic                eop;

    assign req = s_axis_tvalid & cfg_en;

    // Cyclic search starting just after the most recently completed grant.
    always_comb begin : rr_search
        logic [GNT_WD-1:0] cand;
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            cand = GNT_WD'((int'(last_gnt) + i) % PORT_NUM);
            if (!arb_hit && req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin : out_mux
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (state == XFER) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (gnt == GNT_WD'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*DATA_WD +: DATA_WD];
                    m_axis_tkeep     = s_axis_tkeep[i*KEEP_WD +: KEEP_WD];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    m_axis_tuser     = s_axis_tuser[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign eop = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin : next_state
        state_nxt = state;
        case (state)
            ARB:     if (arb_hit) state_nxt = XFER;
            XFER:    if (eop) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Soft reset leaves gnt alone so sts_grant keeps reporting the last grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            gnt         <= '0;
            last_gnt    <= GNT_WD'(PORT_NUM - 1);
            sts_pkt_cnt <= '0;
        end else if (cfg_rst) begin
            state       <= ARB;
            last_gnt    <= GNT_WD'(PORT_NUM - 1);
            sts_pkt_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && arb_hit) begin
                gnt <= arb_idx;
            end
            if (eop) begin
                last_gnt    <= gnt;
                sts_pkt_cnt <= sts_pkt_cnt + CFG_WD'(1);
            end
        end
    end

    assign sts_busy  = (state == XFER);
    assign sts_grant = gnt;

endmodule

// File: tb/tb_cmip_pkt_arb_rr.sv
// Directed bench for cmip_pkt_arb_rr: packet table for round-robin/disable ordering,
// plus hand sequences for reset, backpressure, truncation, single-beat and wrap.
module tb_cmip_pkt_arb_rr;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int PN = 4;
    localparam int GW = 2;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_rst = 1'b0;
    logic [PN-1:0]     cfg_en = '0;
    logic [PN*DW-1:0]  s_axis_tdata = '0;
    logic [PN*KW-1:0]  s_axis_tkeep = '0;
    logic [PN-1:0]     s_axis_tvalid = '0;
    logic [PN-1:0]     s_axis_tready;
    logic [PN-1:0]     s_axis_tlast = '0;
    logic [PN-1:0]     s_axis_tuser = '0;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              sts_busy;
    logic [GW-1:0]     sts_grant;
    logic [CW-1:0]     sts_pkt_cnt;

    int checks = 0;
    int passed = 0;
    int bcnt[PN];
    int plen[PN];

    typedef struct {
        logic          rst_before;
        logic [PN-1:0] en;
        logic [PN-1:0] en_mid;
        int            port;
        int            cnt;
    } vec_t;

    vec_t vecs[14];

    cmip_pkt_arb_rr #(.DATA_WD(DW), .PORT_NUM(PN), .GNT_WD(GW), .CFG_WD(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst), .cfg_en(cfg_en),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .sts_busy(sts_busy), .sts_grant(sts_grant), .sts_pkt_cnt(sts_pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] expdata(input int p, input int b);
        return {8'(8'hA0 + p), 8'h5A, 16'(b)};
    endfunction

    function automatic logic [KW-1:0] expkeep(input int p);
        return KW'(4'hF >> p);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive();
        for (int p = 0; p < PN; p++) begin
            s_axis_tdata[p*DW +: DW] = expdata(p, bcnt[p]);
            s_axis_tkeep[p*KW +: KW] = expkeep(p);
            s_axis_tlast[p]          = (bcnt[p] == plen[p] - 1);
            s_axis_tuser[p]          = (bcnt[p] == 0);
        end
    endtask

    task automatic upd();
        drive();
        #1;
    endtask

    // One clock: source beat counters advance on handshakes seen before the edge.
    task automatic cyc();
        logic [PN-1:0] hs;
        hs = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        for (int p = 0; p < PN; p++)
            if (hs[p]) bcnt[p] = (bcnt[p] + 1) % plen[p];
        @(negedge clk);
        upd();
    endtask

    task automatic run_pkt(input int exp, input bit bp, input logic [PN-1:0] en_mid,
                           input string tag);
        int w, beats, bad;
        bit done;
        logic [PN-1:0] exp_rdy;
        w = 0; beats = 0; bad = 0; done = 1'b0;
        while (!sts_busy && w < 20) begin
            cyc();
            w++;
        end
        chk({tag, " arb_latency"}, 64'(w), 64'd1);
        chk({tag, " grant"}, 64'(sts_grant), 64'(exp));
        w = 0;
        while (!done && w < 60) begin
            m_axis_tready = bp ? (w % 2 == 0) : 1'b1;
            upd();
            exp_rdy = PN'(m_axis_tready) << exp;
            if (s_axis_tready !== exp_rdy) bad++;
            if (m_axis_tvalid !== s_axis_tvalid[exp]) bad++;
            if (m_axis_tvalid && m_axis_tready) begin
                if (m_axis_tdata !== expdata(exp, bcnt[exp])) bad++;
                if (m_axis_tkeep !== expkeep(exp)) bad++;
                if (m_axis_tlast !== (bcnt[exp] == plen[exp] - 1)) bad++;
                if (m_axis_tuser !== (bcnt[exp] == 0)) bad++;
                beats++;
                if (beats == 1) cfg_en = en_mid;
                if (m_axis_tlast) done = 1'b1;
            end
            cyc();
            w++;
        end
        m_axis_tready = 1'b1;
        upd();
        chk({tag, " beats"}, 64'(beats), 64'(plen[exp]));
        chk({tag, " beat_errors"}, 64'(bad), 64'd0);
        chk({tag, " gap"}, 64'(sts_busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 4'hF, 0, 1};
        vecs[1]  = '{1'b0, 4'hF, 4'hF, 1, 2};
        vecs[2]  = '{1'b0, 4'hF, 4'hF, 2, 3};
        vecs[3]  = '{1'b0, 4'hF, 4'hF, 3, 4};
        vecs[4]  = '{1'b0, 4'hF, 4'hF, 0, 5};
        vecs[5]  = '{1'b0, 4'hF, 4'hF, 1, 6};
        vecs[6]  = '{1'b1, 4'hB, 4'hB, 0, 1};
        vecs[7]  = '{1'b0, 4'hB, 4'hB, 1, 2};
        vecs[8]  = '{1'b0, 4'hB, 4'hB, 3, 3};
        vecs[9]  = '{1'b0, 4'hB, 4'hB, 0, 4};
        vecs[10] = '{1'b0, 4'hB, 4'h9, 1, 5};
        vecs[11] = '{1'b0, 4'h9, 4'h9, 3, 6};
        vecs[12] = '{1'b0, 4'h9, 4'h9, 0, 7};
        vecs[13] = '{1'b0, 4'h9, 4'h9, 3, 8};

        for (int p = 0; p < PN; p++) begin
            bcnt[p] = 0;
            plen[p] = 4;
        end

        // Reset with sources valid: everything must stay quiet.
        cfg_en = 4'hF;
        s_axis_tvalid = 4'hF;
        upd();
        repeat (3) @(negedge clk);
        #1;
        chk("rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst m_tuser", 64'(m_axis_tuser), 64'd0);
        chk("rst m_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst m_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst busy", 64'(sts_busy), 64'd0);
        chk("rst grant", 64'(sts_grant), 64'd0);
        chk("rst pkt_cnt", 64'(sts_pkt_cnt), 64'd0);
        @(negedge clk);
        s_axis_tvalid = '0;
        rst_n = 1'b1;
        upd();

        // Single port, three 8-beat packets.
        cfg_en = 4'h1;
        plen[0] = 8;
        s_axis_tvalid = 4'h1;
        upd();
        for (int k = 0; k < 3; k++) run_pkt(0, 1'b0, 4'h1, "single");
        chk("single pkt_cnt", 64'(sts_pkt_cnt), 64'd3);

        // Packet-level ordering table.
        plen[0] = 4;
        for (int v = 0; v < 14; v++) begin
            if (vecs[v].rst_before) begin
                cfg_rst = 1'b1;
                cfg_en = vecs[v].en;
                s_axis_tvalid = 4'hF;
                upd();
                cyc();
                chk($sformatf("vec%0d softrst busy", v), 64'(sts_busy), 64'd0);
                cfg_rst = 1'b0;
                upd();
            end else begin
                cfg_en = vecs[v].en;
                upd();
            end
            run_pkt(vecs[v].port, 1'b0, vecs[v].en_mid, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d pkt_cnt", v), 64'(sts_pkt_cnt), 64'(vecs[v].cnt));
        end

        // Backpressure on a 6-beat packet from port 0.
        cfg_en = 4'hF;
        s_axis_tvalid = 4'h1;
        plen[0] = 6;
        upd();
        run_pkt(0, 1'b1, 4'hF, "bp");
        chk("bp pkt_cnt", 64'(sts_pkt_cnt), 64'd9);

        // Truncate a port-2 packet with a one-cycle soft reset after beat 3.
        plen[2] = 8;
        s_axis_tvalid = 4'h4;
        upd();
        cyc();
        chk("trunc busy", 64'(sts_busy), 64'd1);
        chk("trunc grant", 64'(sts_grant), 64'd2);
        repeat (3) cyc();
        chk("trunc beats_sent", 64'(bcnt[2]), 64'd3);
        cfg_rst = 1'b1;
        s_axis_tvalid = 4'hA;
        upd();
        cyc();
        chk("trunc busy_after", 64'(sts_busy), 64'd0);
        chk("trunc pkt_cnt", 64'(sts_pkt_cnt), 64'd0);
        chk("trunc m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("trunc s_tready", 64'(s_axis_tready), 64'd0);
        cfg_rst = 1'b0;
        bcnt[2] = 0;
        upd();
        run_pkt(1, 1'b0, 4'hF, "post_trunc");
        chk("post_trunc pkt_cnt", 64'(sts_pkt_cnt), 64'd1);

        // Single-beat packets alternating between ports 1 and 3.
        plen[1] = 1;
        plen[3] = 1;
        bcnt[1] = 0;
        bcnt[3] = 0;
        upd();
        for (int k = 0; k < 4; k++) begin
            run_pkt((k % 2 == 0) ? 3 : 1, 1'b0, 4'hF, $sformatf("sb%0d", k));
            chk($sformatf("sb%0d pkt_cnt", k), 64'(sts_pkt_cnt), 64'(k + 2));
        end

        // Counter wrap from all-ones.
        s_axis_tvalid = '0;
        upd();
        cyc();
        force dut.sts_pkt_cnt = {CW{1'b1}};
        cyc();
        release dut.sts_pkt_cnt;
        upd();
        chk("wrap preload", 64'(sts_pkt_cnt), 64'hFFFF_FFFF);
        s_axis_tvalid = 4'h2;
        upd();
        run_pkt(1, 1'b0, 4'hF, "wrap");
        chk("wrap pkt_cnt", 64'(sts_pkt_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
